// File: rtl/auth_attempt_ctrl.sv
// auth_attempt_ctrl: turns per-attempt comparator verdicts into an access
// outcome. A match opens a fixed-length grant window. Consecutive failures are
// counted, and reaching the failure limit starts a timed lockout.
module auth_attempt_ctrl #(
   parameter int MAX_FAILS   = 3,   // 1..15
   parameter int LOCK_CYCLES = 16,  // 1..65535
   parameter int UNLOCK_HOLD = 4    // 1..65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       attempt_valid,
   input  logic       matched,
   input  logic       unmatched,
   output logic       attempt_ready,
   output logic       granted,
   output logic       denied,
   output logic       locked,
   output logic [3:0] fail_count,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'b00,
      S_UNLOCKED = 2'b01,
      S_LOCKED   = 2'b10,
      S_BAD      = 2'b11
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [3:0]  fail_count_q, fail_count_d;
   logic        granted_q, granted_d;
   logic        denied_q, denied_d;
   logic        locked_q, locked_d;

   logic        is_pass;
   logic [3:0]  fail_inc;

   // Only an exact matched=1/unmatched=0 verdict counts as a pass.
   // Both-high and both-low verdicts are malformed and are treated as failures.
   assign is_pass  = matched & ~unmatched;
   assign fail_inc = fail_count_q + 4'd1;

   // Next-state logic. Windows end at the edge where the timer reads zero, so
   // a window loaded with N-1 lasts exactly N cycles.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      fail_count_d = fail_count_q;
      granted_d    = granted_q;
      locked_d     = locked_q;
      denied_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            granted_d = 1'b0;
            locked_d  = 1'b0;
            if (attempt_valid) begin
               if (is_pass) begin
                  state_d      = S_UNLOCKED;
                  granted_d    = 1'b1;
                  fail_count_d = 4'd0;
                  timer_d      = 16'(UNLOCK_HOLD - 1);
               end else begin
                  denied_d     = 1'b1;
                  fail_count_d = fail_inc;
                  if (fail_inc == 4'(MAX_FAILS)) begin
                     state_d  = S_LOCKED;
                     locked_d = 1'b1;
                     timer_d  = 16'(LOCK_CYCLES - 1);
                  end
               end
            end
         end
         S_UNLOCKED: begin
            if (timer_q == 16'd0) begin
               state_d   = S_IDLE;
               granted_d = 1'b0;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         S_LOCKED: begin
            if (timer_q == 16'd0) begin
               state_d      = S_IDLE;
               locked_d     = 1'b0;
               fail_count_d = 4'd0;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         default: begin
            // The unused encoding recovers to a clean IDLE.
            state_d   = S_IDLE;
            granted_d = 1'b0;
            locked_d  = 1'b0;
            timer_d   = 16'd0;
         end
      endcase
   end

   // Register update. A synchronous reset overrides any open window.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         timer_q      <= 16'd0;
         fail_count_q <= 4'd0;
         granted_q    <= 1'b0;
         denied_q     <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         fail_count_q <= fail_count_d;
         granted_q    <= granted_d;
         denied_q     <= denied_d;
         locked_q     <= locked_d;
      end
   end

   assign attempt_ready = (state_q == S_IDLE);
   assign granted       = granted_q;
   assign denied        = denied_q;
   assign locked        = locked_q;
   assign fail_count    = fail_count_q;
   assign state         = state_q;

endmodule

// File: tb/tb_auth_attempt_ctrl.sv
// Directed bench for auth_attempt_ctrl with the default parameters
// (MAX_FAILS=3, LOCK_CYCLES=16, UNLOCK_HOLD=4). Inputs change and outputs are
// sampled on the falling edge. Each check compares the packed output vector
// {ready, state, granted, denied, locked, fail_count} with a hand-computed value.
module tb_auth_attempt_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       attempt_valid = 1'b0;
   logic       matched = 1'b0;
   logic       unmatched = 1'b0;
   logic       attempt_ready, granted, denied, locked;
   logic [3:0] fail_count;
   logic [1:0] state;

   int n_checks = 0;
   int n_pass   = 0;

   auth_attempt_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .attempt_valid (attempt_valid),
      .matched       (matched),
      .unmatched     (unmatched),
      .attempt_ready (attempt_ready),
      .granted       (granted),
      .denied        (denied),
      .locked        (locked),
      .fail_count    (fail_count),
      .state         (state)
   );

   always #5 clk = ~clk;

   wire [9:0] obs = {attempt_ready, state, granted, denied, locked, fail_count};

   // Builds an expected output vector (this does not compare anything).
   function automatic logic [9:0] ex(input logic r, input logic [1:0] s,
                                     input logic g, input logic d,
                                     input logic l, input logic [3:0] fc);
      return {r, s, g, d, l, fc};
   endfunction

   // Advance one clock: the rising edge does the work, then wait for the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic m, input logic u);
      attempt_valid = v; matched = m; unmatched = u;
   endtask

   task automatic do_reset();
      rst = 1'b1; drive(0, 0, 0); tick(); rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [9:0] e;
      rst = 1'b1; drive(1, 1, 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         e = ex(1, 2'b00, 0, 0, 0, 4'd0);
         n_checks++;
         if (obs !== e) $display("FAIL reset_c%0d got %b want %b", i, obs, e); else n_pass++;
      end
      rst = 1'b0; drive(0, 0, 0);
   endtask

   task automatic test_pass();
      logic [9:0] e;
      drive(1, 1, 0); tick(); drive(0, 0, 0);
      e = ex(0, 2'b01, 1, 0, 0, 4'd0);
      n_checks++;
      if (obs !== e) $display("FAIL pass_accept got %b want %b", obs, e); else n_pass++;
      for (int i = 2; i <= 4; i++) begin
         tick();
         n_checks++;
         if (obs !== e) $display("FAIL pass_hold_c%0d got %b want %b", i, obs, e); else n_pass++;
      end
      tick();
      e = ex(1, 2'b00, 0, 0, 0, 4'd0);
      n_checks++;
      if (obs !== e) $display("FAIL pass_end got %b want %b", obs, e); else n_pass++;
   endtask

   task automatic test_lockout();
      logic [9:0] e;
      drive(1, 0, 1);
      tick();
      e = ex(1, 2'b00, 0, 1, 0, 4'd1);
      n_checks++;
      if (obs !== e) $display("FAIL lock_f1 got %b want %b", obs, e); else n_pass++;
      tick();
      e = ex(1, 2'b00, 0, 1, 0, 4'd2);
      n_checks++;
      if (obs !== e) $display("FAIL lock_f2 got %b want %b", obs, e); else n_pass++;
      tick(); drive(0, 0, 0);
      e = ex(0, 2'b10, 0, 1, 1, 4'd3);
      n_checks++;
      if (obs !== e) $display("FAIL lock_f3 got %b want %b", obs, e); else n_pass++;
      e = ex(0, 2'b10, 0, 0, 1, 4'd3);
      for (int i = 2; i <= 16; i++) begin
         tick();
         n_checks++;
         if (obs !== e) $display("FAIL lock_hold_c%0d got %b want %b", i, obs, e); else n_pass++;
      end
      tick();
      e = ex(1, 2'b00, 0, 0, 0, 4'd0);
      n_checks++;
      if (obs !== e) $display("FAIL lock_end got %b want %b", obs, e); else n_pass++;
   endtask

   task automatic test_fail_fail_pass();
      logic [9:0] e;
      do_reset();
      drive(1, 0, 1); tick();
      drive(1, 0, 1); tick();
      e = ex(1, 2'b00, 0, 1, 0, 4'd2);
      n_checks++;
      if (obs !== e) $display("FAIL ffp_f2 got %b want %b", obs, e); else n_pass++;
      drive(1, 1, 0); tick(); drive(0, 0, 0);
      e = ex(0, 2'b01, 1, 0, 0, 4'd0);
      n_checks++;
      if (obs !== e) $display("FAIL ffp_pass got %b want %b", obs, e); else n_pass++;
      for (int i = 0; i < 4; i++) tick();
      e = ex(1, 2'b00, 0, 0, 0, 4'd0);
      n_checks++;
      if (obs !== e) $display("FAIL ffp_idle got %b want %b", obs, e); else n_pass++;
      drive(1, 0, 1); tick(); drive(0, 0, 0);
      e = ex(1, 2'b00, 0, 1, 0, 4'd1);
      n_checks++;
      if (obs !== e) $display("FAIL ffp_refail got %b want %b", obs, e); else n_pass++;
   endtask

   task automatic test_malformed();
      logic [9:0] e;
      do_reset();
      drive(1, 1, 1); tick();
      e = ex(1, 2'b00, 0, 1, 0, 4'd1);
      n_checks++;
      if (obs !== e) $display("FAIL malf_11 got %b want %b", obs, e); else n_pass++;
      drive(1, 0, 0); tick(); drive(0, 0, 0);
      e = ex(1, 2'b00, 0, 1, 0, 4'd2);
      n_checks++;
      if (obs !== e) $display("FAIL malf_00 got %b want %b", obs, e); else n_pass++;
      tick();
      e = ex(1, 2'b00, 0, 0, 0, 4'd2);
      n_checks++;
      if (obs !== e) $display("FAIL malf_quiet got %b want %b", obs, e); else n_pass++;
   endtask

   task automatic test_ignored();
      logic [9:0] e;
      do_reset();
      drive(1, 1, 0); tick();
      drive(1, 0, 1);
      e = ex(0, 2'b01, 1, 0, 0, 4'd0);
      for (int i = 2; i <= 4; i++) begin
         tick();
         n_checks++;
         if (obs !== e) $display("FAIL ign_unl_c%0d got %b want %b", i, obs, e); else n_pass++;
      end
      tick();
      e = ex(1, 2'b00, 0, 0, 0, 4'd0);
      n_checks++;
      if (obs !== e) $display("FAIL ign_unl_exit got %b want %b", obs, e); else n_pass++;
      tick();
      e = ex(1, 2'b00, 0, 1, 0, 4'd1);
      n_checks++;
      if (obs !== e) $display("FAIL ign_resume got %b want %b", obs, e); else n_pass++;
      tick(); tick();
      e = ex(0, 2'b10, 0, 1, 1, 4'd3);
      n_checks++;
      if (obs !== e) $display("FAIL ign_lock got %b want %b", obs, e); else n_pass++;
      e = ex(0, 2'b10, 0, 0, 1, 4'd3);
      for (int i = 2; i <= 16; i++) begin
         tick();
         n_checks++;
         if (obs !== e) $display("FAIL ign_lock_c%0d got %b want %b", i, obs, e); else n_pass++;
      end
      tick();
      e = ex(1, 2'b00, 0, 0, 0, 4'd0);
      n_checks++;
      if (obs !== e) $display("FAIL ign_lock_exit got %b want %b", obs, e); else n_pass++;
      tick(); drive(0, 0, 0);
      e = ex(1, 2'b00, 0, 1, 0, 4'd1);
      n_checks++;
      if (obs !== e) $display("FAIL ign_lock_resume got %b want %b", obs, e); else n_pass++;
   endtask

   task automatic test_reset_mid_lock();
      logic [9:0] e;
      do_reset();
      drive(1, 0, 1); tick(); tick(); tick(); drive(0, 0, 0);
      e = ex(0, 2'b10, 0, 1, 1, 4'd3);
      n_checks++;
      if (obs !== e) $display("FAIL rml_lock got %b want %b", obs, e); else n_pass++;
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      e = ex(1, 2'b00, 0, 0, 0, 4'd0);
      n_checks++;
      if (obs !== e) $display("FAIL rml_reset got %b want %b", obs, e); else n_pass++;
      drive(1, 1, 0); tick(); drive(0, 0, 0);
      e = ex(0, 2'b01, 1, 0, 0, 4'd0);
      n_checks++;
      if (obs !== e) $display("FAIL rml_pass got %b want %b", obs, e); else n_pass++;
   endtask

   // granted and locked must never be high together once reset has released.
   always @(negedge clk) begin
      if (!rst) begin
         n_checks++;
         if (granted === 1'b1 && locked === 1'b1)
            $display("FAIL excl got granted=%b locked=%b want not both 1", granted, locked);
         else
            n_pass++;
      end
   end

   initial begin
      test_reset();
      test_pass();
      test_lockout();
      test_fail_fail_pass();
      test_malformed();
      test_ignored();
      test_reset_mid_lock();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/auth_attempt_ctrl.md
Name: auth_attempt_ctrl

Overview:
- Sequential stage directly downstream of the 8-bit setter/guesser comparator.
- Consumes its per-attempt matched/unmatched verdict and decides the access outcome.
- Grants access for a fixed hold window on a match and counts consecutive failures.
- Enforces a timed lockout once the failure limit is reached; feeds the door/indicator logic.

Parameters:
MAX_FAILS, 3, consecutive failed attempts that trigger lockout; legal range 1..15
LOCK_CYCLES, 16, clock cycles spent in LOCKED; legal range 1..65535
UNLOCK_HOLD, 4, clock cycles granted stays high after a match; legal range 1..65535

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  synchronous, active-high reset
attempt_valid  input  1  comparator verdict for one attempt is present this cycle
matched  input  1  comparator says guess equals set code
unmatched  input  1  comparator says guess differs from set code
attempt_ready  output  1  block accepts a verdict this cycle (high only in IDLE)
granted  output  1  access granted; high for the whole UNLOCKED window
denied  output  1  one-cycle pulse per accepted failed attempt
locked  output  1  high for the whole LOCKED window
fail_count  output  4  consecutive failures since last match/lockout expiry
state  output  2  00 IDLE, 01 UNLOCKED, 10 LOCKED (11 never driven)

Behaviour:
- All outputs registered except attempt_ready, which equals (state==IDLE) and is combinational from the state register.
- Reset (rst=1 at a rising edge):
  - state=IDLE, fail_count=0, granted=0, denied=0, locked=0, internal timer=0.
  - Reset overrides any in-progress window.
  - attempt_valid in the same cycle as rst is ignored.
- Acceptance: an attempt is accepted at an edge where attempt_valid=1 and attempt_ready=1. Outcomes are visible in the cycle after that edge (1-cycle latency).
- Verdict decode on acceptance:
  - matched=1, unmatched=0 → pass.
  - Any other combination (0/0 or 1/1) is malformed and is treated as a failure.
- IDLE, pass:
  - → UNLOCKED; granted=1; fail_count=0; timer=UNLOCK_HOLD-1.
- IDLE, failure:
  - denied=1 for exactly one cycle; fail_count increments.
  - If the incremented value equals MAX_FAILS → LOCKED; locked=1; timer=LOCK_CYCLES-1; fail_count holds MAX_FAILS while locked.
  - Otherwise stay IDLE.
- IDLE, no acceptance: hold fail_count; denied=0.
- UNLOCKED:
  - attempt_ready=0; verdicts are ignored and not counted.
  - Timer decrements each cycle. At the edge where timer==0 → IDLE, granted=0.
  - granted is therefore high for exactly UNLOCK_HOLD cycles.
- LOCKED:
  - attempt_ready=0; verdicts are ignored.
  - Timer decrements each cycle. At the edge where timer==0 → IDLE, locked=0, fail_count=0.
  - locked is therefore high for exactly LOCK_CYCLES cycles.
  - The denied pulse of the locking attempt coincides with the first locked cycle.
- Back-to-back attempts in IDLE are accepted every cycle. Each failure produces its own denied pulse, so denied may stay high across consecutive cycles.
- A pass after partial failures clears fail_count; failures are consecutive-only.
- MAX_FAILS=1: the first failure locks immediately.
- UNLOCK_HOLD=1 or LOCK_CYCLES=1: the window lasts exactly one cycle, then returns to IDLE.
- Timer width is 16 bits.
- granted and locked are never high together.
- state=11 is unreachable; if it occurs, return to IDLE on the next edge.

Test Plan:
- Reset then pass:
  - Stimulus: rst for 2 cycles, then valid=1, matched=1, unmatched=0 for 1 cycle.
  - Response: next cycle granted=1, state=01, attempt_ready=0; granted high exactly 4 cycles; then state=00, ready=1, fail_count=0.
- Three failures to lockout:
  - Stimulus: valid=1, matched=0, unmatched=1 for 3 consecutive cycles.
  - Response: fail_count 1, 2, 3; denied high 3 consecutive cycles; locked=1 from the cycle after the third acceptance for exactly 16 cycles; then fail_count=0, state=00.
- Fail, fail, pass:
  - Response: fail_count reaches 2, then clears to 0 with granted=1; no lock.
  - Follow-up: one more failure gives fail_count=1.
- Malformed verdicts:
  - Stimulus: valid with matched=1, unmatched=1, then valid with 0/0.
  - Response: each gives a denied pulse; fail_count=2.
- Ignored attempts:
  - Stimulus: hold valid=1, unmatched=1 throughout UNLOCKED and LOCKED windows.
  - Response: no denied pulses and no fail_count change while ready=0.
  - Counting resumes the first cycle after return to IDLE.
- Reset mid-lock:
  - Stimulus: assert rst 5 cycles into LOCKED.
  - Response: next cycle locked=0, state=00, fail_count=0, ready=1; a following pass grants normally.
